// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and holds the fetched word in an IF/ID register handed to decode by valid/ready.
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_misaligned,
    output logic [31:0] fetch_count
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t      state_r;
    logic [63:0] pc_r;
    logic        xfer_s;
    logic        free_s;
    logic        fire_s;
    logic        misaligned_s;

    // Handshake and fetch-permission terms for the current cycle.
    always_comb begin
        xfer_s       = if_valid && if_ready;
        free_s       = !if_valid || if_ready;
        misaligned_s = (pc_r[1:0] != 2'b00);
        if (state_r == RUN) begin
            fire_s = fetch_en && free_s && !redirect_valid;
        end else begin
            fire_s = 1'b0;
        end
    end

    assign imem_addr = pc_r;

    // PC, fault state machine, IF/ID register and transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            state_r       <= RUN;
            if_valid      <= 1'b0;
            if_pc         <= 64'h0;
            if_instr      <= 32'h0;
            if_misaligned <= 1'b0;
            fetch_count   <= 32'h0;
        end else begin
            // A transfer completes even when a redirect squashes the slot refill.
            if (xfer_s) begin
                fetch_count <= fetch_count + 32'd1;
            end else begin
                fetch_count <= fetch_count;
            end

            if (redirect_valid) begin
                pc_r     <= redirect_pc;
                state_r  <= RUN;
                if_valid <= 1'b0;
            end else if (fire_s) begin
                if_pc    <= pc_r;
                if_valid <= 1'b1;
                if (misaligned_s) begin
                    // Park on the faulting PC until execute redirects us.
                    if_instr      <= NOP_INSTR;
                    if_misaligned <= 1'b1;
                    state_r       <= FAULT;
                end else begin
                    if_instr      <= imem_instr;
                    if_misaligned <= 1'b0;
                    pc_r          <= pc_r + 64'd4;
                end
            end else if (xfer_s) begin
                if_valid <= 1'b0;
            end else begin
                if_valid <= if_valid;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stimulus pushes expected IF/ID
// entries; a negedge monitor pops and compares on every decode transfer.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misaligned;
    logic [31:0] fetch_count;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_misaligned  (if_misaligned),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: three known words, everything else addr + 0x1000_0000.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0:   mem_word = 32'h0000_0011;
            64'h4:   mem_word = 32'h0000_0022;
            64'h8:   mem_word = 32'h0000_0033;
            default: mem_word = a[31:0] + 32'h1000_0000;
        endcase
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] pc, input logic [31:0] instr, input logic mis);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.mis   = mis;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle that will transfer is checked against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && if_valid && if_ready) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer actual_pc=%h required=none", if_pc);
            end else begin
                e = exp_q.pop_front();
                chk("xfer_pc", if_pc, e.pc);
                chk("xfer_instr", {32'h0, if_instr}, {32'h0, e.instr});
                chk("xfer_mis", {63'h0, if_misaligned}, {63'h0, e.mis});
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        if_ready       = 1'b0;
        #2;
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_valid", {63'h0, if_valid}, 64'h0);
        chk("rst_count", {32'h0, fetch_count}, 64'h0);
        chk("rst_pc", if_pc, 64'h0);
        chk("rst_instr", {32'h0, if_instr}, 64'h0);
        chk("rst_mis", {63'h0, if_misaligned}, 64'h0);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Streaming three words, then stop fetching and let the last drain.
        push(64'h0, 32'h0000_0011, 1'b0);
        push(64'h4, 32'h0000_0022, 1'b0);
        push(64'h8, 32'h0000_0033, 1'b0);
        fetch_en = 1'b1;
        if_ready = 1'b1;
        tick(3);
        fetch_en = 1'b0;
        tick(1);
        chk("stream_count", {32'h0, fetch_count}, 64'd3);
        chk("stream_valid", {63'h0, if_valid}, 64'h0);
        chk("stream_addr", imem_addr, 64'hC);

        // Backpressure with if_pc=4 held.
        push(64'h0, 32'h0000_0011, 1'b0);
        push(64'h4, 32'h0000_0022, 1'b0);
        push(64'h8, 32'h0000_0033, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0;
        fetch_en       = 1'b1;
        tick(1);
        redirect_valid = 1'b0;
        tick(2);
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("bp_pc", if_pc, 64'h4);
            chk("bp_instr", {32'h0, if_instr}, 64'h22);
            chk("bp_addr", imem_addr, 64'h8);
            chk("bp_valid", {63'h0, if_valid}, 64'h1);
        end
        if_ready = 1'b1;
        tick(1);
        chk("bp_release_pc", if_pc, 64'h8);

        // Redirect in the same cycle as a transfer.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        tick(1);
        redirect_valid = 1'b0;
        chk("redir_count", {32'h0, fetch_count}, 64'd6);
        chk("redir_valid", {63'h0, if_valid}, 64'h0);
        chk("redir_addr", imem_addr, 64'h100);
        push(64'h100, 32'h1000_0100, 1'b0);
        tick(1);
        chk("redir_pc", if_pc, 64'h100);
        chk("redir_valid2", {63'h0, if_valid}, 64'h1);

        // Misaligned fault: one NOP entry, then no fetches until redirected.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h102;
        tick(1);
        redirect_valid = 1'b0;
        push(64'h102, 32'h0000_0013, 1'b1);
        tick(1);
        chk("fault_pc", if_pc, 64'h102);
        chk("fault_instr", {32'h0, if_instr}, 64'h13);
        chk("fault_mis", {63'h0, if_misaligned}, 64'h1);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            chk("fault_idle_valid", {63'h0, if_valid}, 64'h0);
            chk("fault_idle_addr", imem_addr, 64'h102);
            tick(1);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        push(64'h200, 32'h1000_0200, 1'b0);
        tick(1);
        redirect_valid = 1'b0;
        tick(1);
        chk("recover_pc", if_pc, 64'h200);
        chk("recover_mis", {63'h0, if_misaligned}, 64'h0);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        push(64'hFFFF_FFFF_FFFF_FFFC, 32'h0FFF_FFFC, 1'b0);
        tick(1);
        redirect_valid = 1'b0;
        tick(2);
        if_ready = 1'b0;
        chk("wrap_pc", if_pc, 64'h0);
        chk("wrap_instr", {32'h0, if_instr}, 64'h11);
        chk("wrap_mis", {63'h0, if_misaligned}, 64'h0);
        chk("wrap_valid", {63'h0, if_valid}, 64'h1);
        chk("wrap_count", {32'h0, fetch_count}, 64'd10);

        // Asynchronous reset mid-run with a held entry.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_addr", imem_addr, 64'h0);
        chk("arst_valid", {63'h0, if_valid}, 64'h0);
        chk("arst_count", {32'h0, fetch_count}, 64'h0);
        tick(1);
        #2;
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_pc", if_pc, 64'h0);
        chk("post_rst_valid", {63'h0, if_valid}, 64'h1);

        chk("sb_empty", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
